// File: rtl/vme_bus_arbiter_if.sv
// VME arbitration bus bundle: request/strobe/acknowledge inputs and the
// registered grant/busy/error/owner outputs of the arbiter.
interface vme_bus_arbiter_if;
  // Handshake: a master holds br_n[id] low until it sees bg_n[id] low, then
  // owns the bus (bbsy_n low) until it withdraws br_n before as_n, or until
  // as_n goes high after dtack_n low; the grant drops for one dead cycle after.
  logic [3:0] br_n;
  logic       as_n;
  logic       dtack_n;
  logic [3:0] bg_n;
  logic       bbsy_n;
  logic       berr_n;
  logic [1:0] owner;
  logic       owner_vld;

  // slave = arbiter side, master = requesting agents / bench side
  modport slave (
    input  br_n, as_n, dtack_n,
    output bg_n, bbsy_n, berr_n, owner, owner_vld
  );
  modport master (
    output br_n, as_n, dtack_n,
    input  bg_n, bbsy_n, berr_n, owner, owner_vld
  );
endinterface

// File: rtl/vme_bus_arbiter.sv
// Four-master VME bus arbiter: round-robin or fixed priority grant, one-cycle
// grant latency, transfer tracking, bus-error timeout and a forced dead cycle.
module vme_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter bit          RR_MODE     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  vme_bus_arbiter_if.slave     bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_REL   = 3'd4
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  // Fires on the edge where the counter steps onto TIMEOUT_CYC-1, so the berr
  // pulse coincides with the dead cycle TIMEOUT_CYC-1 cycles after the grant.
  localparam logic [CW-1:0] TO_FIRE = CW'(TIMEOUT_CYC - 2);

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_owner_q, last_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bg_n_q, bg_n_d;
  logic          bbsy_n_q, bbsy_n_d;
  logic          berr_n_q, berr_n_d;
  logic          owner_vld_q, owner_vld_d;

  logic          any_req;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          timeout;
  logic          berr_fire;
  logic          granted;

  // Arbitration
  always_comb begin
    any_req = ~&bus.br_n;
    winner  = 2'd0;
    idx     = 2'd0;
    if (RR_MODE) begin
      // Scan downward and overwrite so the first requester above last_owner wins.
      for (int i = 4; i >= 1; i--) begin
        idx = last_owner_q + 2'(i);
        if (!bus.br_n[idx]) winner = idx;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (!bus.br_n[i]) winner = 2'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      cnt_q        <= '0;
      bg_n_q       <= 4'hF;
      bbsy_n_q     <= 1'b1;
      berr_n_q     <= 1'b1;
      owner_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      bg_n_q       <= bg_n_d;
      bbsy_n_q     <= bbsy_n_d;
      berr_n_q     <= berr_n_d;
      owner_vld_q  <= owner_vld_d;
    end
  end

  // Next state, counter and round-robin history
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    berr_fire = 1'b0;
    timeout   = (cnt_q == TO_FIRE);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          owner_d = winner;
        end
      end
      ST_GRANT: begin
        if (timeout) begin
          state_d   = ST_REL;
          berr_fire = 1'b1;
        end else if (!bus.as_n) begin
          state_d = ST_XFER;
        end else if (bus.br_n[owner_q]) begin
          state_d = ST_REL;
        end
      end
      ST_XFER: begin
        // A late acknowledge still beats the timeout.
        if (!bus.dtack_n) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d   = ST_REL;
          berr_fire = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.as_n) state_d = ST_REL;
      end
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_q == ST_IDLE && state_d == ST_GRANT) begin
      cnt_d = '0;
    end else if (state_q == ST_GRANT || state_q == ST_XFER) begin
      cnt_d = cnt_q + 1'b1;
    end

    last_owner_d = last_owner_q;
    if (state_d == ST_REL && state_q != ST_REL) last_owner_d = owner_q;
  end

  // Outputs, registered from the next state so they change with the state
  always_comb begin
    granted     = (state_d == ST_GRANT) || (state_d == ST_XFER) || (state_d == ST_DONE);
    bg_n_d      = 4'hF;
    if (granted) bg_n_d[owner_d] = 1'b0;
    bbsy_n_d    = ~granted;
    owner_vld_d = granted;
    berr_n_d    = ~berr_fire;
  end

  assign bus.bg_n      = bg_n_q;
  assign bus.bbsy_n    = bbsy_n_q;
  assign bus.berr_n    = berr_n_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = owner_vld_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Bench for vme_bus_arbiter: round-robin and fixed-priority instances share
// stimulus; a tenure-level model is compared every cycle plus literal checks.
module tb_vme_bus_arbiter;
  localparam int T = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] br_n    = 4'hF;
  logic       as_n    = 1'b1;
  logic       dtack_n = 1'b1;

  vme_bus_arbiter_if bus_rr();
  vme_bus_arbiter_if bus_fp();
  assign bus_rr.br_n    = br_n;
  assign bus_rr.as_n    = as_n;
  assign bus_rr.dtack_n = dtack_n;
  assign bus_fp.br_n    = br_n;
  assign bus_fp.as_n    = as_n;
  assign bus_fp.dtack_n = dtack_n;

  logic [2:0] dbg_rr, dbg_fp;

  vme_bus_arbiter #(.TIMEOUT_CYC(T), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst_n), .bus(bus_rr), .dbg_state(dbg_rr));
  vme_bus_arbiter #(.TIMEOUT_CYC(T), .RR_MODE(1'b0)) u_fp (
    .clk(clk), .rst(rst_n), .bus(bus_fp), .dbg_state(dbg_fp));

  logic [3:0] act_bg [2];
  logic       act_bbsy [2];
  logic       act_berr [2];
  logic [1:0] act_owner [2];
  logic       act_vld [2];
  assign act_bg[0]    = bus_rr.bg_n;
  assign act_bg[1]    = bus_fp.bg_n;
  assign act_bbsy[0]  = bus_rr.bbsy_n;
  assign act_bbsy[1]  = bus_fp.bbsy_n;
  assign act_berr[0]  = bus_rr.berr_n;
  assign act_berr[1]  = bus_fp.berr_n;
  assign act_owner[0] = bus_rr.owner;
  assign act_owner[1] = bus_fp.owner;
  assign act_vld[0]   = bus_rr.owner_vld;
  assign act_vld[1]   = bus_fp.owner_vld;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tenure-level model: who holds the bus, how long since the grant, what the
  // master has done so far, and whether this is the dead cycle after a tenure.
  typedef struct {
    int holder;
    int age;
    bit rel;
    bit berr;
    bit got_as;
    bit got_ack;
    int last;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.holder = -1; r.age = 0; r.rel = 1'b0; r.berr = 1'b0;
    r.got_as = 1'b0; r.got_ack = 1'b0; r.last = 3;
    return r;
  endfunction

  function automatic int pick(input logic [3:0] br, input int last, input bit rr);
    if (rr) begin
      for (int i = 1; i <= 4; i++) if (!br[(last + i) % 4]) return (last + i) % 4;
    end else begin
      for (int i = 0; i < 4; i++) if (!br[i]) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic [3:0] br, input logic as,
                                input logic ack, input bit rr);
    mdl_t n;
    bit   rel_now;
    bit   expires;
    int   w;
    n = s;
    n.berr  = 1'b0;
    rel_now = 1'b0;
    // the bus error lands on the (T-1)th cycle after the grant cycle
    expires = (s.age + 1 == T - 1);
    if (s.rel) begin
      n.rel = 1'b0;
      n.holder = -1;
    end else if (s.holder < 0) begin
      w = pick(br, s.last, rr);
      if (w >= 0) begin
        n.holder = w; n.age = 0; n.got_as = 1'b0; n.got_ack = 1'b0;
      end
    end else begin
      if (s.got_ack) begin
        rel_now = as;
      end else if (!s.got_as) begin
        if (expires) begin rel_now = 1'b1; n.berr = 1'b1; end
        else if (!as) n.got_as = 1'b1;
        else if (br[s.holder]) rel_now = 1'b1;
      end else begin
        if (!ack) n.got_ack = 1'b1;
        else if (expires) begin rel_now = 1'b1; n.berr = 1'b1; end
      end
      n.age = s.age + 1;
      if (rel_now) begin n.rel = 1'b1; n.last = s.holder; end
    end
    return n;
  endfunction

  mdl_t m [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mdl_reset();
      m[1] <= mdl_reset();
    end else begin
      m[0] <= step(m[0], br_n, as_n, dtack_n, 1'b1);
      m[1] <= step(m[1], br_n, as_n, dtack_n, 1'b0);
    end
  end

  // Scoreboard compare, every cycle out of reset
  task automatic compare_dut(input int d);
    logic [3:0] ebg;
    bit         g;
    string      tag;
    tag = (d == 0) ? "rr" : "fp";
    g   = (m[d].holder >= 0) && !m[d].rel;
    ebg = 4'hF;
    if (g) ebg[m[d].holder] = 1'b0;
    chk({tag, ".bg_n"}, act_bg[d], ebg);
    chk({tag, ".bbsy_n"}, act_bbsy[d], !g);
    chk({tag, ".owner_vld"}, act_vld[d], g);
    chk({tag, ".berr_n"}, act_berr[d], !m[d].berr);
    if (g) chk({tag, ".owner"}, act_owner[d], m[d].holder);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      compare_dut(0);
      compare_dut(1);
    end
  end

  // Driver tasks
  task automatic wait_grant(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (act_bg[0] !== 4'hF) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: no grant within 20 cycles, bg_n=%0h expected a low bit", tag, act_bg[0]);
  endtask

  // Called on the grant cycle; returns on the dead cycle.
  task automatic do_xfer();
    as_n = 1'b0;
    @(negedge clk);
    dtack_n = 1'b0;
    @(negedge clk);
    as_n = 1'b1;
    dtack_n = 1'b1;
    @(negedge clk);
  endtask

  logic [3:0] arb_tab [4];
  logic       berr_seen [9];
  logic [3:0] bg_seen [9];

  initial begin
    arb_tab[0] = 4'b0110; arb_tab[1] = 4'b0011;
    arb_tab[2] = 4'b1100; arb_tab[3] = 4'b0101;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset.bg_n", act_bg[d], 4'hF);
      chk("reset.bbsy_n", act_bbsy[d], 1'b1);
      chk("reset.berr_n", act_berr[d], 1'b1);
      chk("reset.owner", act_owner[d], 2'd0);
      chk("reset.owner_vld", act_vld[d], 1'b0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Masters 0 and 2: rr serves 0 then 2, fixed serves 0 twice
    br_n = 4'b1010;
    wait_grant("rr_first");
    chk("rr_first.bg_n", act_bg[0], 4'b1110);
    chk("rr_first.owner", act_owner[0], 2'd0);
    do_xfer();
    chk("rr_first.rel_bg_n", act_bg[0], 4'hF);
    chk("rr_first.rel_bbsy_n", act_bbsy[0], 1'b1);
    wait_grant("rr_second");
    chk("rr_second.bg_n", act_bg[0], 4'b1011);
    chk("rr_second.owner", act_owner[0], 2'd2);
    chk("fp_second.bg_n", act_bg[1], 4'b1110);
    do_xfer();
    br_n = 4'hF;
    repeat (2) @(negedge clk);

    // Master 1 times out with as_n low and no dtack_n
    br_n = 4'b1101;
    wait_grant("timeout");
    as_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      berr_seen[i] = act_berr[0];
      bg_seen[i]   = act_bg[0];
      if (i == 7) begin br_n = 4'hF; as_n = 1'b1; end
    end
    chk("timeout.berr_before", berr_seen[6], 1'b1);
    chk("timeout.berr_pulse", berr_seen[7], 1'b0);
    chk("timeout.bg_released", bg_seen[7], 4'hF);
    chk("timeout.berr_after", berr_seen[8], 1'b1);
    @(negedge clk);

    // dtack_n on the very edge the timeout would fire
    br_n = 4'b1101;
    wait_grant("late_ack");
    as_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) dtack_n = 1'b0;
    end
    @(negedge clk);
    chk("late_ack.berr_n", act_berr[0], 1'b1);
    chk("late_ack.bg_n", act_bg[0], 4'b1101);
    dtack_n = 1'b1;
    br_n = 4'hF;
    @(negedge clk);
    chk("late_ack.still_done", act_bg[0], 4'b1101);
    as_n = 1'b1;
    @(negedge clk);
    chk("late_ack.rel", act_bg[0], 4'hF);
    @(negedge clk);

    // Master 3 withdraws before strobing
    br_n = 4'b0111;
    wait_grant("withdraw");
    chk("withdraw.bg_n", act_bg[0], 4'b0111);
    chk("withdraw.owner", act_owner[0], 2'd3);
    br_n = 4'hF;
    @(negedge clk);
    chk("withdraw.rel_bg_n", act_bg[0], 4'hF);
    chk("withdraw.berr_n", act_berr[0], 1'b1);
    @(negedge clk);

    // Arbitration patterns, checked by the model
    foreach (arb_tab[t]) begin
      br_n = arb_tab[t];
      wait_grant("arb_tab");
      br_n = 4'hF;
      repeat (2) @(negedge clk);
    end

    // All masters requesting across three tenures
    br_n = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      wait_grant("all_req");
      chk("all_req.fp_owner", act_owner[1], 2'd0);
      chk("all_req.fp_bg_n", act_bg[1], 4'b1110);
      do_xfer();
      chk("all_req.fp_gap", act_bg[1], 4'hF);
    end
    br_n = 4'hF;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-transfer
    br_n = 4'b0000;
    wait_grant("mid_reset");
    as_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_reset.bg_n", act_bg[d], 4'hF);
      chk("mid_reset.bbsy_n", act_bbsy[d], 1'b1);
      chk("mid_reset.owner_vld", act_vld[d], 1'b0);
    end
    as_n = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset.rr_bg_n", act_bg[0], 4'b1110);
    chk("post_reset.fp_bg_n", act_bg[1], 4'b1110);
    br_n = 4'hF;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
